// File: rtl/ps2_key_sequencer_pkg.sv
// Shared scan-code constants, FSM state encoding and sequencing helpers for the
// PS/2 key sequencer.
package ps2_key_sequencer_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam logic [7:0] PS2_LSHIFT     = 8'h12;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_SH_MK = 4'd1,
        ST_EX_MK = 4'd2,
        ST_CD_MK = 4'd3,
        ST_HOLD  = 4'd4,
        ST_EX_BK = 4'd5,
        ST_F0_BK = 4'd6,
        ST_CD_BK = 4'd7,
        ST_SH_F0 = 4'd8,
        ST_SH_BK = 4'd9
    } seq_state_t;

    typedef struct packed {
        logic       shift;
        logic       extended;
        logic [7:0] code;
    } key_evt_t;

    function automatic seq_state_t first_state(input logic shift, input logic extended);
        if (shift)
            return ST_SH_MK;
        else if (extended)
            return ST_EX_MK;
        else
            return ST_CD_MK;
    endfunction

    // Successor after the current byte has been taken (or the hold has elapsed).
    function automatic seq_state_t next_state(input seq_state_t st, input logic shift,
                                              input logic extended, input logic hold_en);
        case (st)
            ST_SH_MK: return extended ? ST_EX_MK : ST_CD_MK;
            ST_EX_MK: return ST_CD_MK;
            ST_CD_MK: return hold_en ? ST_HOLD : (extended ? ST_EX_BK : ST_F0_BK);
            ST_HOLD:  return extended ? ST_EX_BK : ST_F0_BK;
            ST_EX_BK: return ST_F0_BK;
            ST_F0_BK: return ST_CD_BK;
            ST_CD_BK: return shift ? ST_SH_F0 : ST_IDLE;
            ST_SH_F0: return ST_SH_BK;
            default:  return ST_IDLE;
        endcase
    endfunction

    function automatic logic [7:0] state_byte(input seq_state_t st, input logic [7:0] code);
        case (st)
            ST_SH_MK, ST_SH_BK: return PS2_LSHIFT;
            ST_EX_MK, ST_EX_BK: return PS2_PREFIX_EXT;
            ST_F0_BK, ST_SH_F0: return PS2_PREFIX_BRK;
            ST_CD_MK, ST_CD_BK: return code;
            default:            return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/ps2_key_sequencer_fifo.sv
// Synchronous key-event FIFO with occupancy count; read data is shown ahead
// from the head entry.
module key_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     i_clk,
    input  logic                     i_resetn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rd_ptr];

    // A push while full is refused even if a pop frees a slot this cycle.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Buffers key events and expands each into a set-2 make/break scan-code byte
// stream with optional left-shift wrapping and E0 prefixes.
module ps2_key_sequencer
    import ps2_key_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int HOLD_CYCLES = 0
) (
    input  logic                          clk_25mhz,
    input  logic                          resetn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_code,
    input  logic                          in_extended,
    input  logic                          in_shift,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_byte,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int              HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic            HOLD_EN   = (HOLD_CYCLES > 0);

    key_evt_t   w_wdata;
    key_evt_t   w_rdata;
    key_evt_t   r_evt;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       r_avail;
    seq_state_t r_state;
    seq_state_t w_first;
    seq_state_t w_nxt;
    logic [HW-1:0] r_hold_cnt;

    assign w_wdata = {in_shift, in_extended, in_code};

    key_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(key_evt_t))
    ) u_fifo (
        .i_clk    (clk_25mhz),
        .i_resetn (resetn),
        .i_push   (in_valid),
        .i_wdata  (w_wdata),
        .i_pop    (w_pop),
        .o_rdata  (w_rdata),
        .o_level  (fifo_level),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    assign in_ready = ~w_full;
    assign busy     = (r_state != ST_IDLE) | ~w_empty;

    // Pop is qualified by a registered non-empty flag, which sets the two-edge
    // accept-to-output latency and the one idle cycle between events.
    assign w_pop   = (r_state == ST_IDLE) & r_avail & ~w_empty;
    assign w_first = first_state(w_rdata.shift, w_rdata.extended);
    assign w_nxt   = next_state(r_state, r_evt.shift, r_evt.extended, HOLD_EN);

    always_ff @(posedge clk_25mhz) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_evt      <= '0;
            r_avail    <= 1'b0;
            r_hold_cnt <= '0;
            out_valid  <= 1'b0;
            out_byte   <= 8'h00;
            overflow   <= 1'b0;
        end else begin
            r_avail  <= ~w_empty;
            overflow <= in_valid & w_full;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_evt     <= w_rdata;
                        r_state   <= w_first;
                        out_valid <= 1'b1;
                        out_byte  <= state_byte(w_first, w_rdata.code);
                    end
                end
                ST_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_state   <= w_nxt;
                        out_valid <= 1'b1;
                        out_byte  <= state_byte(w_nxt, r_evt.code);
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HW'(1);
                    end
                end
                default: begin
                    if (out_ready) begin
                        r_state    <= w_nxt;
                        r_hold_cnt <= '0;
                        out_valid  <= (w_nxt != ST_IDLE) && (w_nxt != ST_HOLD);
                        out_byte   <= state_byte(w_nxt, r_evt.code);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench: byte streams, latency, stall, overflow, hold gap and mid-sequence reset.
module tb_ps2_key_sequencer;

    logic       clk_25mhz = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic [7:0] in_code;
    logic       in_extended;
    logic       in_shift;
    logic       out_ready;

    logic       in_ready, out_valid, busy, overflow;
    logic [7:0] out_byte;
    logic [3:0] fifo_level;
    logic       h_in_ready, h_out_valid, h_busy, h_overflow;
    logic [7:0] h_out_byte;
    logic [3:0] h_fifo_level;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ovf_total = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int t0[$];
    int t1[$];
    logic [7:0] exp_q[$];

    always #20 clk_25mhz = ~clk_25mhz;

    ps2_key_sequencer #(.FIFO_DEPTH(8), .HOLD_CYCLES(0)) dut (
        .clk_25mhz(clk_25mhz), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .in_extended(in_extended), .in_shift(in_shift),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .busy(busy), .overflow(overflow), .fifo_level(fifo_level));

    ps2_key_sequencer #(.FIFO_DEPTH(8), .HOLD_CYCLES(5)) dut_h (
        .clk_25mhz(clk_25mhz), .resetn(resetn),
        .in_valid(in_valid), .in_ready(h_in_ready), .in_code(in_code),
        .in_extended(in_extended), .in_shift(in_shift),
        .out_valid(h_out_valid), .out_ready(out_ready), .out_byte(h_out_byte),
        .busy(h_busy), .overflow(h_overflow), .fifo_level(h_fifo_level));

    always @(posedge clk_25mhz) cyc <= cyc + 1;

    always @(negedge clk_25mhz) begin
        if (resetn) begin
            if (out_valid && out_ready) begin
                q0.push_back(out_byte);
                t0.push_back(cyc);
            end
            if (h_out_valid && out_ready) begin
                q1.push_back(h_out_byte);
                t1.push_back(cyc);
            end
            if (overflow)
                ovf_total = ovf_total + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_25mhz);
        #1;
    endtask

    task automatic do_reset;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic push(input logic [7:0] c, input logic e, input logic s);
        in_code     = c;
        in_extended = e;
        in_shift    = s;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || h_busy) && n < 300) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, busy | h_busy}, 32'd0);
    endtask

    task automatic chk_seq(input string tag, input logic [7:0] q[$], input int base,
                           input logic [7:0] exp[$]);
        chk({tag, "_len"}, q.size() - base, exp.size());
        for (int i = 0; i < exp.size(); i++)
            if (base + i < q.size())
                chk(tag, {24'd0, q[base+i]}, {24'd0, exp[i]});
    endtask

    initial begin
        int b, b1, n, ob;
        logic       sv, stable;
        logic [7:0] sb;
        #(1ms);
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int b, b1, n, ob;
        logic       sv, stable;
        logic [7:0] sb;
        resetn = 1'b0; in_valid = 1'b0; in_code = 8'h00;
        in_extended = 1'b0; in_shift = 1'b0; out_ready = 1'b0;
        do_reset();

        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_byte", {24'd0, out_byte}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_level", {28'd0, fifo_level}, 32'd0);

        // plain key and accept-to-output latency
        out_ready = 1'b1;
        b = q0.size();
        push(8'h1C, 1'b0, 1'b0);
        chk("lat_level", {28'd0, fifo_level}, 32'd1);
        tick();
        chk("lat_n1_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("lat_n2_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_n2_byte", {24'd0, out_byte}, 32'h1C);
        wait_idle("plain_idle");
        exp_q = '{8'h1C, 8'hF0, 8'h1C};
        chk_seq("plain_seq", q0, b, exp_q);

        b = q0.size();
        push(8'h75, 1'b1, 1'b0);
        wait_idle("ext_idle");
        exp_q = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        chk_seq("ext_seq", q0, b, exp_q);

        b = q0.size();
        push(8'h1C, 1'b0, 1'b1);
        wait_idle("shift_idle");
        exp_q = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12};
        chk_seq("shift_seq", q0, b, exp_q);

        // stall 20 cycles after three bytes have gone
        b = q0.size();
        push(8'h75, 1'b1, 1'b1);
        n = 0;
        while (q0.size() - b < 3 && n < 50) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        sv = out_valid;
        sb = out_byte;
        stable = 1'b1;
        repeat (20) begin
            tick();
            if (out_valid !== sv || out_byte !== sb)
                stable = 1'b0;
        end
        chk("stall_valid", {31'd0, sv}, 32'd1);
        chk("stall_byte", {24'd0, sb}, 32'hE0);
        chk("stall_stable", {31'd0, stable}, 32'd1);
        out_ready = 1'b1;
        wait_idle("stall_idle");
        exp_q = '{8'h12, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hF0, 8'h12};
        chk_seq("stall_seq", q0, b, exp_q);

        // overflow: one event parked in the FSM, then 10 pushes into the FIFO
        do_reset();
        b = q0.size();
        push(8'hA0, 1'b0, 1'b0);
        tick(); tick(); tick();
        chk("ovf_pre_level", {28'd0, fifo_level}, 32'd0);
        chk("ovf_pre_valid", {31'd0, out_valid}, 32'd1);
        ob = ovf_total;
        in_valid = 1'b1;
        in_extended = 1'b0;
        in_shift = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_code = 8'h10 + 8'(i);
            tick();
            if (i == 6)
                chk("ovf_ready_7", {31'd0, in_ready}, 32'd1);
            if (i == 7)
                chk("ovf_ready_8", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        tick();
        chk("ovf_level", {28'd0, fifo_level}, 32'd8);
        chk("ovf_in_ready", {31'd0, in_ready}, 32'd0);
        chk("ovf_pulses", ovf_total - ob, 32'd2);
        out_ready = 1'b1;
        wait_idle("ovf_idle");
        exp_q = '{8'hA0, 8'hF0, 8'hA0};
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            exp_q.push_back(8'hF0);
            exp_q.push_back(8'h10 + 8'(i));
        end
        chk_seq("ovf_seq", q0, b, exp_q);

        // hold gap: HOLD_CYCLES=0 vs 5
        do_reset();
        out_ready = 1'b1;
        b = q0.size();
        b1 = q1.size();
        push(8'h1C, 1'b0, 1'b0);
        wait_idle("hold_idle");
        exp_q = '{8'h1C, 8'hF0, 8'h1C};
        chk_seq("hold0_seq", q0, b, exp_q);
        chk_seq("hold5_seq", q1, b1, exp_q);
        chk("hold0_gap", (t0.size() >= b + 2) ? t0[b+1] - t0[b] : -1, 32'd1);
        chk("hold5_gap", (t1.size() >= b1 + 2) ? t1[b1+1] - t1[b1] : -1, 32'd6);

        // reset right after the E0 prefix has been taken
        do_reset();
        out_ready = 1'b1;
        b = q0.size();
        push(8'h75, 1'b1, 1'b0);
        n = 0;
        while (q0.size() == b && n < 50) begin
            tick();
            n++;
        end
        resetn = 1'b0;
        tick();
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_level", {28'd0, fifo_level}, 32'd0);
        chk("mrst_byte", {24'd0, out_byte}, 32'd0);
        resetn = 1'b1;
        tick();
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (5) tick();
        chk("mrst_bytes", q0.size() - b, 32'd1);
        chk("mrst_first", (q0.size() > b) ? {24'd0, q0[b]} : 32'hFFFF, 32'hE0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
